// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its environment.
// The supervisor connects through the slave modport. The PLL wrapper or bench connects through the master modport.
interface pll_lock_supervisor_if #(
    parameter int NUM_CLOCKS = 2,
    parameter int CNT_W      = 8
);
    logic                  locked;
    logic                  relock_req;
    logic                  cnt_clr;
    logic                  pll_rst;
    logic [NUM_CLOCKS-1:0] chan_rst;
    logic                  ready;
    logic [CNT_W-1:0]      loss_cnt;
    logic [CNT_W-1:0]      timeout_cnt;
    logic [2:0]            state;

    modport slave (
        input  locked, relock_req, cnt_clr,
        output pll_rst, chan_rst, ready, loss_cnt, timeout_cnt, state
    );

    modport master (
        output locked, relock_req, cnt_clr,
        input  pll_rst, chan_rst, ready, loss_cnt, timeout_cnt, state
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Supervises PLL reset and lock qualification, and releases the output-domain resets in staggered order.
// On lock loss, timeout or relock request it returns to RESET and retries automatically.
module pll_lock_supervisor #(
    parameter int NUM_CLOCKS      = 2,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int STABLE_CYCLES   = 1024,
    parameter int STAGGER_CYCLES  = 8,
    parameter int CNT_W           = 8
) (
    input logic                  refclk,
    input logic                  rst,
    pll_lock_supervisor_if.slave sup
);
    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_e;

    localparam int REL_LAST = (NUM_CLOCKS - 1) * STAGGER_CYCLES;
    localparam int M1   = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int M2   = (M1 > STABLE_CYCLES) ? M1 : STABLE_CYCLES;
    localparam int TMAX = (M2 > REL_LAST + 1) ? M2 : REL_LAST + 1;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] HOLD_LAST   = TW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] REL_LAST_T  = TW'(REL_LAST);

    state_e                state_q, state_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  locked_m_q, locked_s_q;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_CLOCKS-1:0] chan_rst_q, chan_rst_d;
    logic                  ready_q, ready_d;
    logic [CNT_W-1:0]      loss_q, loss_d;
    logic [CNT_W-1:0]      to_q, to_d;
    logic                  loss_inc, to_inc;

    // The two-flop synchroniser is a pure delay line. It is not reset.
    always_ff @(posedge refclk) begin
        locked_m_q <= sup.locked;
        locked_s_q <= locked_m_q;
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q + TW'(1);
        loss_inc = 1'b0;
        to_inc   = 1'b0;
        if (sup.relock_req) begin
            state_d = S_RESET;
            tmr_d   = '0;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (tmr_q == HOLD_LAST) begin
                        state_d = S_WAIT_LOCK;
                        tmr_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = S_STABLE;
                        tmr_d   = '0;
                    end else if (tmr_q == TO_LAST) begin
                        state_d = S_RESET;
                        tmr_d   = '0;
                        to_inc  = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s_q) begin
                        state_d = S_WAIT_LOCK;
                        tmr_d   = '0;
                    end else if (tmr_q == STABLE_LAST) begin
                        state_d = S_RELEASE;
                        tmr_d   = '0;
                    end
                end
                S_RELEASE: begin
                    if (!locked_s_q) begin
                        state_d  = S_RESET;
                        tmr_d    = '0;
                        loss_inc = 1'b1;
                    end else if (tmr_q == REL_LAST_T) begin
                        state_d = S_RUN;
                        tmr_d   = '0;
                    end
                end
                S_RUN: begin
                    tmr_d = '0;
                    if (!locked_s_q) begin
                        state_d  = S_RESET;
                        loss_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = S_RESET;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state, so the registered outputs line up with state_q.
    always_comb begin
        pll_rst_d = (state_d == S_RESET);
        ready_d   = (state_d == S_RUN);
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            chan_rst_d[i] = !((state_d == S_RUN) ||
                              ((state_d == S_RELEASE) && (tmr_d >= TW'(i * STAGGER_CYCLES))));
        end
        loss_d = loss_q;
        to_d   = to_q;
        if (sup.cnt_clr) begin
            loss_d = '0;
            to_d   = '0;
        end else begin
            if (loss_inc && (loss_q != {CNT_W{1'b1}})) loss_d = loss_q + CNT_W'(1);
            if (to_inc && (to_q != {CNT_W{1'b1}}))     to_d   = to_q + CNT_W'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= S_RESET;
            tmr_q      <= '0;
            pll_rst_q  <= 1'b1;
            chan_rst_q <= '1;
            ready_q    <= 1'b0;
            loss_q     <= '0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            pll_rst_q  <= pll_rst_d;
            chan_rst_q <= chan_rst_d;
            ready_q    <= ready_d;
            loss_q     <= loss_d;
            to_q       <= to_d;
        end
    end

    assign sup.pll_rst     = pll_rst_q;
    assign sup.chan_rst    = chan_rst_q;
    assign sup.ready       = ready_q;
    assign sup.loss_cnt    = loss_q;
    assign sup.timeout_cnt = to_q;
    assign sup.state       = state_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
// Expected values are hand-derived cycle tables indexed from the first RESET cycle (j=0).
module tb_pll_lock_supervisor;
  localparam int NC = 3;
  localparam int CW = 4;

  logic refclk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];

  pll_lock_supervisor_if #(.NUM_CLOCKS(NC), .CNT_W(CW)) sup_if ();

  pll_lock_supervisor #(
    .NUM_CLOCKS(NC), .RST_HOLD_CYCLES(4), .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8), .STAGGER_CYCLES(2), .CNT_W(CW)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .sup   (sup_if)
  );

  // clock / reset
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // driver tasks: every action happens on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Returns at the falling edge where rst has just dropped; that cycle is j=0 (RESET, hold count 0).
  task automatic do_reset();
    @(negedge refclk);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  // {state, chan_rst, pll_rst, ready} for an uninterrupted bring-up with locked steady high
  function automatic logic [7:0] seq_vec(input int j);
    logic [2:0] st;
    logic [2:0] ch;
    if (j <= 3)       begin st = 3'd0; ch = 3'b111; end
    else if (j == 4)  begin st = 3'd1; ch = 3'b111; end
    else if (j <= 12) begin st = 3'd2; ch = 3'b111; end
    else if (j <= 14) begin st = 3'd3; ch = 3'b110; end
    else if (j <= 16) begin st = 3'd3; ch = 3'b100; end
    else if (j == 17) begin st = 3'd3; ch = 3'b000; end
    else              begin st = 3'd4; ch = 3'b000; end
    return {st, ch, (st == 3'd0), (st == 3'd4)};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {sup_if.state, sup_if.chan_rst, sup_if.pll_rst, sup_if.ready};
  endfunction

  task automatic test_reset();
    sup_if.locked = 1'b1;
    do_reset();
    n_cmp++; if (sup_if.pll_rst !== 1'b1) begin n_err++; $display("FAIL reset_pll_rst got %b want 1", sup_if.pll_rst); end
    n_cmp++; if (sup_if.chan_rst !== 3'b111) begin n_err++; $display("FAIL reset_chan_rst got %b want 111", sup_if.chan_rst); end
    n_cmp++; if (sup_if.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", sup_if.ready); end
    n_cmp++; if (sup_if.loss_cnt !== 4'd0) begin n_err++; $display("FAIL reset_loss_cnt got %0d want 0", sup_if.loss_cnt); end
    n_cmp++; if (sup_if.timeout_cnt !== 4'd0) begin n_err++; $display("FAIL reset_timeout_cnt got %0d want 0", sup_if.timeout_cnt); end
    n_cmp++; if (sup_if.state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", sup_if.state); end
  endtask

  task automatic test_startup();
    logic [7:0] e;
    sup_if.locked = 1'b1;
    do_reset();
    for (int j = 0; j <= 18; j++) exp_q.push_back(seq_vec(j));
    for (int j = 0; j <= 18; j++) begin
      if (j > 0) tick(1);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_vec() !== e) begin
        n_err++; $display("FAIL startup j=%0d got %h want %h", j, obs_vec(), e);
      end
    end
    n_cmp++; if (sup_if.loss_cnt !== 4'd0 || sup_if.timeout_cnt !== 4'd0) begin
      n_err++; $display("FAIL startup_counters got %0d/%0d want 0/0", sup_if.loss_cnt, sup_if.timeout_cnt);
    end
  endtask

  // Entered in RUN; locked drops for one cycle and the supervisor relocks on its own.
  task automatic test_lock_loss();
    sup_if.locked = 1'b0;
    tick(1);
    sup_if.locked = 1'b1;
    tick(1);
    n_cmp++; if (sup_if.state !== 3'd4) begin n_err++; $display("FAIL loss_still_run got %0d want 4", sup_if.state); end
    tick(1);
    n_cmp++; if (obs_vec() !== seq_vec(0)) begin n_err++; $display("FAIL loss_reset got %h want %h", obs_vec(), seq_vec(0)); end
    n_cmp++; if (sup_if.loss_cnt !== 4'd1) begin n_err++; $display("FAIL loss_cnt got %0d want 1", sup_if.loss_cnt); end
    for (int j = 1; j <= 18; j++) begin
      tick(1);
      n_cmp++;
      if (obs_vec() !== seq_vec(j)) begin n_err++; $display("FAIL loss_relock j=%0d got %h want %h", j, obs_vec(), seq_vec(j)); end
    end
    n_cmp++; if (sup_if.loss_cnt !== 4'd1 || sup_if.timeout_cnt !== 4'd0) begin
      n_err++; $display("FAIL loss_after got %0d/%0d want 1/0", sup_if.loss_cnt, sup_if.timeout_cnt);
    end
  endtask

  // Entered in RUN with loss_cnt=1.
  task automatic test_relock_and_clear();
    sup_if.relock_req = 1'b1;
    tick(1);
    sup_if.relock_req = 1'b0;
    n_cmp++; if (obs_vec() !== seq_vec(0)) begin n_err++; $display("FAIL relock_reset got %h want %h", obs_vec(), seq_vec(0)); end
    n_cmp++; if (sup_if.loss_cnt !== 4'd1 || sup_if.timeout_cnt !== 4'd0) begin
      n_err++; $display("FAIL relock_counters got %0d/%0d want 1/0", sup_if.loss_cnt, sup_if.timeout_cnt);
    end
    for (int j = 1; j <= 18; j++) begin
      tick(1);
      n_cmp++;
      if (obs_vec() !== seq_vec(j)) begin n_err++; $display("FAIL relock_seq j=%0d got %h want %h", j, obs_vec(), seq_vec(j)); end
    end
    // The clear lands on the same edge as the loss increment.
    sup_if.locked = 1'b0;
    tick(1);
    sup_if.locked = 1'b1;
    tick(1);
    sup_if.cnt_clr = 1'b1;
    tick(1);
    sup_if.cnt_clr = 1'b0;
    n_cmp++; if (sup_if.state !== 3'd0) begin n_err++; $display("FAIL clr_state got %0d want 0", sup_if.state); end
    n_cmp++; if (sup_if.loss_cnt !== 4'd0) begin n_err++; $display("FAIL clr_loss_cnt got %0d want 0", sup_if.loss_cnt); end
    sup_if.relock_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      n_cmp++;
      if (obs_vec() !== seq_vec(0)) begin n_err++; $display("FAIL relock_held k=%0d got %h want %h", k, obs_vec(), seq_vec(0)); end
    end
    sup_if.relock_req = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick(1);
      n_cmp++;
      if (obs_vec() !== seq_vec(j)) begin n_err++; $display("FAIL relock_hold_restart j=%0d got %h want %h", j, obs_vec(), seq_vec(j)); end
    end
  endtask

  // A one-cycle glitch is seen in the 5th STABLE cycle (j=9); the bring-up then slips by 6 cycles.
  task automatic test_stable_glitch();
    logic [7:0] e;
    sup_if.locked = 1'b1;
    do_reset();
    for (int j = 0; j <= 24; j++) begin
      if (j > 0) tick(1);
      e = (j <= 9) ? seq_vec(j) : seq_vec(j - 6);
      n_cmp++;
      if (obs_vec() !== e) begin n_err++; $display("FAIL glitch j=%0d got %h want %h", j, obs_vec(), e); end
      if (j == 7) sup_if.locked = 1'b0;
      if (j == 8) sup_if.locked = 1'b1;
    end
    n_cmp++; if (sup_if.loss_cnt !== 4'd0) begin n_err++; $display("FAIL glitch_loss_cnt got %0d want 0", sup_if.loss_cnt); end
  endtask

  task automatic test_rst_mid_release();
    sup_if.locked = 1'b1;
    do_reset();
    tick(18);
    sup_if.locked = 1'b0;
    tick(1);
    sup_if.locked = 1'b1;
    tick(2);
    tick(13);
    n_cmp++; if (obs_vec() !== seq_vec(13) || sup_if.loss_cnt !== 4'd1) begin
      n_err++; $display("FAIL midrel_pre got %h/%0d want %h/1", obs_vec(), sup_if.loss_cnt, seq_vec(13));
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_cmp++; if (sup_if.chan_rst !== 3'b111) begin n_err++; $display("FAIL midrel_chan_rst got %b want 111", sup_if.chan_rst); end
    n_cmp++; if (sup_if.pll_rst !== 1'b1 || sup_if.ready !== 1'b0 || sup_if.state !== 3'd0) begin
      n_err++; $display("FAIL midrel_ctrl got pll_rst=%b ready=%b state=%0d want 1 0 0", sup_if.pll_rst, sup_if.ready, sup_if.state);
    end
    n_cmp++; if (sup_if.loss_cnt !== 4'd0 || sup_if.timeout_cnt !== 4'd0) begin
      n_err++; $display("FAIL midrel_counters got %0d/%0d want 0/0", sup_if.loss_cnt, sup_if.timeout_cnt);
    end
    for (int j = 1; j <= 5; j++) begin
      tick(1);
      n_cmp++;
      if (obs_vec() !== seq_vec(j)) begin n_err++; $display("FAIL midrel_restart j=%0d got %h want %h", j, obs_vec(), seq_vec(j)); end
    end
  endtask

  // locked never rises: 4 cycles RESET + 32 WAIT_LOCK per attempt; timeout_cnt saturates at 15.
  task automatic test_timeout();
    logic [7:0] e;
    logic [7:0] o;
    int ph;
    int nt;
    sup_if.locked = 1'b0;
    do_reset();
    for (int j = 0; j <= 36 * 17; j++) begin
      if (j > 0) tick(1);
      ph = j % 36;
      nt = (j / 36 > 15) ? 15 : j / 36;
      e = {((ph < 4) ? 3'd0 : 3'd1), (ph < 4), 4'(nt)};
      o = {sup_if.state, sup_if.pll_rst, sup_if.timeout_cnt};
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL timeout j=%0d got %h want %h", j, o, e); end
    end
    n_cmp++; if (sup_if.loss_cnt !== 4'd0 || sup_if.chan_rst !== 3'b111) begin
      n_err++; $display("FAIL timeout_side got loss=%0d chan=%b want 0 111", sup_if.loss_cnt, sup_if.chan_rst);
    end
  endtask

  initial begin
    rst = 1'b1;
    sup_if.locked = 1'b0;
    sup_if.relock_req = 1'b0;
    sup_if.cnt_clr = 1'b0;
    test_reset();
    test_startup();
    test_lock_loss();
    test_relock_and_clear();
    test_stable_glitch();
    test_rst_mid_release();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
